// File: rtl/uart_rx_frame_controller_if.sv
// ============================================================================
// uart_rx_frame_controller_if : byte-in / frame-out bundle for the frame controller
// Revision 1.0
// ============================================================================
`default_nettype none

interface uart_rx_frame_controller_if #(
  parameter int LEN_W  = 5,
  parameter int ADDR_W = 4
);
  logic              rx_done;
  logic [7:0]        rx_data;
  logic              frm_valid;
  logic              frm_ready;
  logic [LEN_W-1:0]  frm_len;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;

  modport master (
    output rx_done, rx_data, frm_ready, rd_addr,
    input  frm_valid, frm_len, rd_data
  );

  modport slave (
    input  rx_done, rx_data, frm_ready, rd_addr,
    output frm_valid, frm_len, rd_data
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx_frame_controller.sv
// ============================================================================
// uart_rx_frame_controller : frames SYNC/LEN/payload/CHK bytes into a held packet
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_rx_frame_controller #(
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter int         MAX_LEN       = 16,
  parameter int         LEN_W         = 5,
  parameter int         ADDR_W        = 4,
  parameter int         TIMEOUT_TICKS = 2560
) (
  input  wire logic                 clk_i,
  input  wire logic                 rst_ni,
  input  wire logic                 s_tick_i,
  uart_rx_frame_controller_if.slave bus,
  output logic                      busy_o,
  output logic                      err_chk_o,
  output logic                      err_len_o,
  output logic                      err_timeout_o,
  output logic                      err_ovr_o
);

  localparam logic [15:0] C_TMO_LAST = 16'(TIMEOUT_TICKS - 1);
  localparam logic [7:0]  C_MAX_LEN  = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHK     = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx_q;
  logic [LEN_W-1:0] frm_len_q;
  logic [7:0]       chk_q;
  logic [15:0]      tmo_q;
  logic             frm_valid_q;
  logic             busy_q;
  logic             err_chk_q;
  logic             err_len_q;
  logic             err_timeout_q;
  logic             err_ovr_q;
  logic [7:0]       buf_q [2**ADDR_W];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      idx_q         <= '0;
      frm_len_q     <= '0;
      chk_q         <= '0;
      tmo_q         <= '0;
      frm_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      err_chk_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_ovr_q     <= 1'b0;
    end else begin
      err_chk_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_ovr_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.rx_done && bus.rx_data == SYNC_BYTE) begin
            state_q <= S_LEN;
            busy_q  <= 1'b1;
            tmo_q   <= '0;
          end
        end
        S_LEN, S_PAYLOAD, S_CHK: begin
          // A byte arriving on the expiry tick takes priority over the timeout
          if (bus.rx_done) begin
            tmo_q <= '0;
            if (state_q == S_LEN) begin
              if (bus.rx_data == 8'h00 || bus.rx_data > C_MAX_LEN) begin
                err_len_q <= 1'b1;
                state_q   <= S_IDLE;
                busy_q    <= 1'b0;
              end else begin
                len_q   <= bus.rx_data[LEN_W-1:0];
                chk_q   <= bus.rx_data;
                idx_q   <= '0;
                state_q <= S_PAYLOAD;
              end
            end else if (state_q == S_PAYLOAD) begin
              chk_q <= chk_q ^ bus.rx_data;
              idx_q <= idx_q + LEN_W'(1);
              if (idx_q == len_q - LEN_W'(1)) begin
                state_q <= S_CHK;
              end
            end else begin
              if (bus.rx_data == chk_q) begin
                state_q     <= S_HOLD;
                frm_valid_q <= 1'b1;
                frm_len_q   <= len_q;
              end else begin
                err_chk_q <= 1'b1;
                state_q   <= S_IDLE;
                busy_q    <= 1'b0;
              end
            end
          end else if (s_tick_i) begin
            if (tmo_q == C_TMO_LAST) begin
              err_timeout_q <= 1'b1;
              state_q       <= S_IDLE;
              busy_q        <= 1'b0;
            end else begin
              tmo_q <= tmo_q + 16'd1;
            end
          end
        end
        S_HOLD: begin
          if (bus.rx_done) begin
            err_ovr_q <= 1'b1;
          end
          if (frm_valid_q && bus.frm_ready) begin
            frm_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          frm_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Payload storage is deliberately left unreset; only the FSM guards its validity
  always_ff @(posedge clk_i) begin
    if (state_q == S_PAYLOAD && bus.rx_done) begin
      buf_q[idx_q[ADDR_W-1:0]] <= bus.rx_data;
    end
  end

  assign bus.frm_valid = frm_valid_q;
  assign bus.frm_len   = frm_len_q;
  assign bus.rd_data   = buf_q[bus.rd_addr];
  assign busy_o        = busy_q;
  assign err_chk_o     = err_chk_q;
  assign err_len_o     = err_len_q;
  assign err_timeout_o = err_timeout_q;
  assign err_ovr_o     = err_ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frame_controller.sv
// ============================================================================
// tb_uart_rx_frame_controller : directed self-checking bench for the frame controller
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_frame_controller;

  logic clk;
  logic rst_n;
  logic s_tick;
  logic busy;
  logic err_chk;
  logic err_len;
  logic err_timeout;
  logic err_ovr;
  int   total;
  int   bad;

  uart_rx_frame_controller_if #(.LEN_W(5), .ADDR_W(4)) bus ();

  uart_rx_frame_controller dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .s_tick_i      (s_tick),
    .bus           (bus.slave),
    .busy_o        (busy),
    .err_chk_o     (err_chk),
    .err_len_o     (err_len),
    .err_timeout_o (err_timeout),
    .err_ovr_o     (err_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic tick);
    @(negedge clk);
    bus.rx_done = 1'b1;
    bus.rx_data = b;
    s_tick      = tick;
    @(negedge clk);
    bus.rx_done = 1'b0;
    s_tick      = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  endtask

  task automatic accept();
    @(negedge clk);
    bus.frm_ready = 1'b1;
    @(negedge clk);
    bus.frm_ready = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
    bus.rd_addr = a;
    #1;
    chk(tag, {24'h0, bus.rd_data}, {24'h0, exp});
  endtask

  logic [7:0] csum;

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    s_tick        = 1'b0;
    bus.rx_done   = 1'b0;
    bus.rx_data   = 8'h00;
    bus.frm_ready = 1'b0;
    bus.rd_addr   = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'h0, bus.frm_valid}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_len", {27'h0, bus.frm_len}, 0);
    chk("rst_errs", {28'h0, err_chk, err_len, err_timeout, err_ovr}, 0);
    rst_n = 1'b1;

    // good frame: chk = 03^11^22^33 = 03
    send_byte(8'hA5, 1'b0);
    chk("sync_busy", {31'h0, busy}, 1);
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    chk("pre_chk_valid", {31'h0, bus.frm_valid}, 0);
    send_byte(8'h03, 1'b0);
    chk("good_valid", {31'h0, bus.frm_valid}, 1);
    chk("good_len", {27'h0, bus.frm_len}, 3);
    chk("good_noerr", {28'h0, err_chk, err_len, err_timeout, err_ovr}, 0);
    read_chk("good_rd0", 4'd0, 8'h11);
    read_chk("good_rd1", 4'd1, 8'h22);
    read_chk("good_rd2", 4'd2, 8'h33);
    accept();
    chk("acc_valid", {31'h0, bus.frm_valid}, 0);
    chk("acc_busy", {31'h0, busy}, 0);

    // bad checksum: expected 02^10^20 = 32, sent 31
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h31, 1'b0);
    chk("badchk_err", {31'h0, err_chk}, 1);
    chk("badchk_valid", {31'h0, bus.frm_valid}, 0);
    chk("badchk_busy", {31'h0, busy}, 0);
    @(negedge clk);
    chk("badchk_pulse1", {31'h0, err_chk}, 0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h32, 1'b0);
    chk("after_bad_valid", {31'h0, bus.frm_valid}, 1);
    chk("after_bad_len", {27'h0, bus.frm_len}, 2);
    read_chk("after_bad_rd1", 4'd1, 8'h20);
    accept();

    // length bounds
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("len0_err", {31'h0, err_len}, 1);
    chk("len0_busy", {31'h0, busy}, 0);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h11, 1'b0);
    chk("len17_err", {31'h0, err_len}, 1);
    chk("len17_other", {29'h0, err_chk, err_timeout, err_ovr}, 0);
    csum = 8'h10;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h10, 1'b0);
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i * 3 + 1), 1'b0);
      csum = csum ^ 8'(i * 3 + 1);
    end
    send_byte(csum, 1'b0);
    chk("len16_valid", {31'h0, bus.frm_valid}, 1);
    chk("len16_len", {27'h0, bus.frm_len}, 16);
    read_chk("len16_rd0", 4'd0, 8'h01);
    read_chk("len16_rd15", 4'd15, 8'h2E);
    accept();

    // timeout after 2560 idle ticks
    send_byte(8'hA5, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'hAA, 1'b0);
    tick_n(2559);
    chk("tmo_early", {31'h0, err_timeout}, 0);
    chk("tmo_early_busy", {31'h0, busy}, 1);
    tick_n(1);
    chk("tmo_err", {31'h0, err_timeout}, 1);
    chk("tmo_busy", {31'h0, busy}, 0);

    // byte on the expiry tick wins; chk = 04^AA^BB^CC^DD = 04
    send_byte(8'hA5, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'hAA, 1'b0);
    tick_n(2559);
    send_byte(8'hBB, 1'b1);
    chk("tmo_race_err", {31'h0, err_timeout}, 0);
    chk("tmo_race_busy", {31'h0, busy}, 1);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    send_byte(8'h04, 1'b0);
    chk("race_valid", {31'h0, bus.frm_valid}, 1);

    // overrun while held
    send_byte(8'hA5, 1'b0);
    chk("ovr_err", {31'h0, err_ovr}, 1);
    chk("ovr_valid", {31'h0, bus.frm_valid}, 1);
    chk("ovr_len", {27'h0, bus.frm_len}, 4);
    read_chk("ovr_rd0", 4'd0, 8'hAA);
    read_chk("ovr_rd1", 4'd1, 8'hBB);
    accept();
    chk("ovr_acc_valid", {31'h0, bus.frm_valid}, 0);

    // reset mid-payload, then a clean frame
    send_byte(8'hA5, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'h0, busy}, 0);
    chk("midrst_valid", {31'h0, bus.frm_valid}, 0);
    chk("midrst_len", {27'h0, bus.frm_len}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h03, 1'b0);
    chk("rerun_valid", {31'h0, bus.frm_valid}, 1);
    chk("rerun_len", {27'h0, bus.frm_len}, 3);
    read_chk("rerun_rd2", 4'd2, 8'h33);
    accept();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
